// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state codes and data width.
// Used by the receiver and the transmitter.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for asynchronous inputs.
// Flops load rst_val while rst_n is low.
module uart_rx_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] rst_val,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= rst_val;
      q  <= rst_val;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits, mid-bit sampling, valid/ready output.
// Define UART_RX_PARITY_EN to add a parity bit before the stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      rx_frame_err,
  output logic                      rx_parity_err,
  output logic                      rx_overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST = 3'(UART_DATA_BITS - 1);

  logic                      rx_s;
  logic [2:0]                state;
  logic [CW-1:0]             cnt;
  logic [2:0]                idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      par_bad;
  logic                      hs;

  assign hs = rx_valid & rx_ready;

  uart_rx_sync #(.W(1)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .rst_val (1'b1),
    .d       (rx),
    .q       (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bad       <= 1'b0;
      rx_parity_err <= 1'b0;
    end else begin
      rx_parity_err <= 1'b0;
      if (state == ST_PARITY && cnt == FULL)
        par_bad <= rx_s != (^shreg ^ PARITY_ODD);
      if (state == ST_STOP && cnt == FULL && rx_s && par_bad)
        rx_parity_err <= 1'b1;
    end
  end
`else
  assign par_bad       = 1'b0;
  assign rx_parity_err = 1'b0 & PARITY_ODD;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      idx          <= '0;
      shreg        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_frame_err <= 1'b0;
      if (hs) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          // the edge-detect cycle counts as tick 0 of the start bit
          cnt <= '0;
          if (!rx_s) begin
            state <= ST_START;
            cnt   <= CW'(1);
          end
        end
        ST_START: begin
          cnt <= cnt + 1'b1;
          if (cnt == HALF) begin
            cnt <= '0;
            idx <= '0;
            state <= rx_s ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          cnt <= cnt + 1'b1;
          if (cnt == FULL) begin
            cnt        <= '0;
            shreg[idx] <= rx_s;
            idx        <= idx + 1'b1;
            if (idx == LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          cnt <= cnt + 1'b1;
          if (cnt == FULL) begin
            cnt   <= '0;
            state <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          cnt <= cnt + 1'b1;
          if (cnt == FULL) begin
            cnt <= '0;
            if (!rx_s) begin
              rx_frame_err <= 1'b1;
              state        <= ST_WAIT_IDLE;
            end else begin
              state <= ST_IDLE;
              if (!par_bad) begin
                if (!rx_valid || hs) begin
                  rx_data  <= shreg;
                  rx_valid <= 1'b1;
                end else begin
                  rx_overrun <= 1'b1;
                end
              end
            end
          end
        end
        ST_WAIT_IDLE: begin
          cnt <= '0;
          if (rx_s) state <= ST_IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
